// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority 4-to-2 encoder: first set req bit scanning ptr, ptr+1, ... mod 4.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     enc;

  // Rotating right by ptr puts requester ptr at bit 0, so a fixed
  // lowest-bit-wins encoder yields the offset from ptr.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = IDX_W'(i);
    end
  end

  // Wraps naturally in IDX_W bits.
  assign win_idx = enc + ptr;
  assign any     = |req;

endmodule

// File: rtl/rr_arbiter_4x2.sv
// Round-robin arbiter for four requesters with registered one-hot grant, index and hold limit.
// Latency: 1 cycle req->grant; every release is followed by one dead IDLE cycle.
// Backpressure: requester holds req to keep grant; grant is revoked after MAX_HOLD cycles.
module rr_arbiter_4x2
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [7:0] MAX_HOLD_CNT = 8'(MAX_HOLD);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [IDX_W-1:0] win_idx;
  logic             any;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any) begin
            state       <= GRANT;
            grant       <= idx_to_onehot(win_idx);
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd1;
          end
        end
        GRANT: begin
          if (req[grant_idx] && (hold_cnt < MAX_HOLD_CNT)) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            // Voluntary or forced release; the holder drops to lowest priority.
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= req[grant_idx];
            ptr         <= grant_idx + IDX_W'(1);
            hold_cnt    <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
